// File: rtl/load_align_pkg.sv
// Shared load-path definitions: RV load funct3 codes, FSM states and the
// access size / signedness decode used by the FSM and the extractor.
package load_align_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef enum logic [2:0] {IDLE, RD0, WT0, RD1, WT1, DONE} state_t;

  // Access size in bytes; 0 marks an illegal funct3 for this beat width.
  function automatic logic [3:0] ld_size(input logic [2:0] f3, input logic dw64);
    case (f3)
      F3_LB, F3_LBU: ld_size = 4'd1;
      F3_LH, F3_LHU: ld_size = 4'd2;
      F3_LW:         ld_size = 4'd4;
      F3_LD:         ld_size = dw64 ? 4'd8 : 4'd0;
      F3_LWU:        ld_size = dw64 ? 4'd4 : 4'd0;
      default:       ld_size = 4'd0;
    endcase
  endfunction

  function automatic logic ld_signed(input logic [2:0] f3);
    case (f3)
      F3_LB, F3_LH, F3_LW, F3_LD: ld_signed = 1'b1;
      default:                    ld_signed = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_align_unit_extract.sv
// Combinational right-justify and sign/zero-extend of a one- or two-beat
// load window.
module load_extract
  import load_align_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFF_W  = $clog2(DATA_W/8)
) (
  input  logic [2*DATA_W-1:0] merged,
  input  logic [OFF_W-1:0]    off,
  input  logic [2:0]          funct3,
  output logic [DATA_W-1:0]   data
);

  logic [DATA_W-1:0] shifted;
  logic [3:0]        size;
  logic              sgn;
  logic signed [7:0]  b_s;
  logic signed [15:0] h_s;
  logic signed [31:0] w_s;

  assign size    = ld_size(funct3, DATA_W == 64);
  assign sgn     = ld_signed(funct3);
  assign shifted = DATA_W'(merged >> {off, 3'b000});
  assign b_s     = shifted[7:0];
  assign h_s     = shifted[15:0];
  assign w_s     = shifted[31:0];

  always_comb begin
    data = shifted;
    case (size)
      4'd1: if (sgn) data = DATA_W'(b_s); else data = DATA_W'(shifted[7:0]);
      4'd2: if (sgn) data = DATA_W'(h_s); else data = DATA_W'(shifted[15:0]);
      4'd4: if (sgn) data = DATA_W'(w_s); else data = DATA_W'(shifted[31:0]);
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/load_align_unit.sv
// MEM-stage load unit: issues one or two beat-aligned reads, merges them and
// returns a right-justified, extended writeback packet or an error.
module load_align_unit
  import load_align_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int MISALIGN_EN = 1
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_funct3,
  input  logic [4:0]        req_rd,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  output logic              mem_rsp_ready,
  input  logic [DATA_W-1:0] mem_rsp_data,
  input  logic              mem_rsp_err,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [DATA_W-1:0] wb_data,
  output logic [4:0]        wb_rd,
  output logic              wb_err
);

  localparam int BYTES = DATA_W/8;
  localparam int OFF_W = $clog2(BYTES);

  state_t            state, next_state;
  logic              err_q, err_d, split_q;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        funct3_q;
  logic [4:0]        rd_q;
  logic [DATA_W-1:0] beat0_q, beat1_q, ext_data;
  logic [3:0]        req_size;
  logic [4:0]        req_end;
  logic              req_split, req_bad;
  logic [ADDR_W-1:0] beat0_addr, beat1_addr;

  assign req_size   = ld_size(req_funct3, DATA_W == 64);
  assign req_end    = 5'(req_addr[OFF_W-1:0]) + 5'(req_size);
  assign req_split  = req_end > 5'(BYTES);
  assign req_bad    = (req_size == 4'd0) || (req_split && (MISALIGN_EN == 0));
  assign beat0_addr = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign beat1_addr = beat0_addr + ADDR_W'(BYTES);

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state   <= IDLE;
      err_q   <= 1'b0;
      split_q <= 1'b0;
    end else begin
      state <= next_state;
      err_q <= err_d;
      if (state == IDLE && req_valid) split_q <= req_split;
    end
  end

  // Beat 1 is cleared on accept so a single-beat load merges against zero.
  always_ff @(posedge ACLK) begin
    if (state == IDLE && req_valid) begin
      addr_q   <= req_addr;
      funct3_q <= req_funct3;
      rd_q     <= req_rd;
      beat1_q  <= '0;
    end
    if (state == WT0 && mem_rsp_valid) beat0_q <= mem_rsp_data;
    if (state == WT1 && mem_rsp_valid) beat1_q <= mem_rsp_data;
  end

  always_comb begin
    next_state    = state;
    err_d         = err_q;
    req_ready     = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;
    mem_rsp_ready = 1'b0;
    wb_valid      = 1'b0;
    case (state)
      IDLE: begin
        req_ready = ARESETn;
        if (req_valid) begin
          err_d      = req_bad;
          next_state = req_bad ? DONE : RD0;
        end
      end
      RD0: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = beat0_addr;
        if (mem_req_ready) next_state = WT0;
      end
      WT0: begin
        mem_rsp_ready = 1'b1;
        if (mem_rsp_valid) begin
          err_d      = mem_rsp_err;
          next_state = (split_q && !mem_rsp_err) ? RD1 : DONE;
        end
      end
      RD1: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = beat1_addr;
        if (mem_req_ready) next_state = WT1;
      end
      WT1: begin
        mem_rsp_ready = 1'b1;
        if (mem_rsp_valid) begin
          err_d      = mem_rsp_err;
          next_state = DONE;
        end
      end
      DONE: begin
        wb_valid = 1'b1;
        if (wb_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  load_extract #(.DATA_W(DATA_W), .OFF_W(OFF_W)) u_extract (
    .merged ({beat1_q, beat0_q}),
    .off    (addr_q[OFF_W-1:0]),
    .funct3 (funct3_q),
    .data   (ext_data)
  );

  assign wb_err  = (state == DONE) && err_q;
  assign wb_data = (state == DONE && !err_q) ? ext_data : '0;
  assign wb_rd   = (state == DONE) ? rd_q : '0;

  always_ff @(posedge ACLK) begin
    if (ARESETn && mem_rsp_valid)
      assert (state == WT0 || state == WT1)
      else $error("load_align_unit: mem_rsp_valid outside a wait state");
  end

endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit: 32-bit split-capable, 32-bit strict
// alignment and 64-bit instances driven one at a time through a selector.
module tb_load_align_unit;
  import load_align_pkg::*;

  logic ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  logic        ARESETn;
  logic        rv [3];
  logic        rspv [3];
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic [4:0]  req_rd;
  logic        mem_req_ready, mem_rsp_err, wb_ready;
  logic [63:0] rsp_data;

  logic        rdy [3], mrv [3], mrsr [3], wbv [3], wbe [3];
  logic [31:0] maddr [3];
  logic [4:0]  wbrd [3];
  logic [31:0] wbd_a, wbd_b;
  logic [63:0] wbd_c;

  logic [1:0]  sel;
  logic        o_rdy, o_mrv, o_mrsr, o_wbv, o_wbe;
  logic [31:0] o_maddr;
  logic [4:0]  o_wbrd;
  logic [63:0] o_wbd;

  int checks = 0;
  int errors = 0;

  load_align_unit #(.DATA_W(32), .ADDR_W(32), .MISALIGN_EN(1)) u_a (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .req_valid(rv[0]), .req_ready(rdy[0]), .req_addr(req_addr),
    .req_funct3(req_funct3), .req_rd(req_rd),
    .mem_req_valid(mrv[0]), .mem_req_ready(mem_req_ready), .mem_req_addr(maddr[0]),
    .mem_rsp_valid(rspv[0]), .mem_rsp_ready(mrsr[0]), .mem_rsp_data(rsp_data[31:0]),
    .mem_rsp_err(mem_rsp_err),
    .wb_valid(wbv[0]), .wb_ready(wb_ready), .wb_data(wbd_a), .wb_rd(wbrd[0]), .wb_err(wbe[0])
  );

  load_align_unit #(.DATA_W(32), .ADDR_W(32), .MISALIGN_EN(0)) u_b (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .req_valid(rv[1]), .req_ready(rdy[1]), .req_addr(req_addr),
    .req_funct3(req_funct3), .req_rd(req_rd),
    .mem_req_valid(mrv[1]), .mem_req_ready(mem_req_ready), .mem_req_addr(maddr[1]),
    .mem_rsp_valid(rspv[1]), .mem_rsp_ready(mrsr[1]), .mem_rsp_data(rsp_data[31:0]),
    .mem_rsp_err(mem_rsp_err),
    .wb_valid(wbv[1]), .wb_ready(wb_ready), .wb_data(wbd_b), .wb_rd(wbrd[1]), .wb_err(wbe[1])
  );

  load_align_unit #(.DATA_W(64), .ADDR_W(32), .MISALIGN_EN(1)) u_c (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .req_valid(rv[2]), .req_ready(rdy[2]), .req_addr(req_addr),
    .req_funct3(req_funct3), .req_rd(req_rd),
    .mem_req_valid(mrv[2]), .mem_req_ready(mem_req_ready), .mem_req_addr(maddr[2]),
    .mem_rsp_valid(rspv[2]), .mem_rsp_ready(mrsr[2]), .mem_rsp_data(rsp_data),
    .mem_rsp_err(mem_rsp_err),
    .wb_valid(wbv[2]), .wb_ready(wb_ready), .wb_data(wbd_c), .wb_rd(wbrd[2]), .wb_err(wbe[2])
  );

  always_comb begin
    o_rdy   = rdy[sel];
    o_mrv   = mrv[sel];
    o_mrsr  = mrsr[sel];
    o_wbv   = wbv[sel];
    o_wbe   = wbe[sel];
    o_maddr = maddr[sel];
    o_wbrd  = wbrd[sel];
    if (sel == 2'd0)      o_wbd = {32'h0, wbd_a};
    else if (sel == 2'd1) o_wbd = {32'h0, wbd_b};
    else                  o_wbd = wbd_c;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  // Full zero-wait load; result must appear exactly three (or five) edges after accept.
  task automatic run(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                     input logic [4:0] rd, input logic [63:0] d0, input logic [63:0] d1,
                     input bit split, input logic [31:0] a0, input logic [31:0] a1,
                     input logic [63:0] exp);
    rv[sel] = 1'b1; req_addr = addr; req_funct3 = f3; req_rd = rd;
    chk({tag, " req_ready"}, 64'(o_rdy), 64'd1);
    step();
    rv[sel] = 1'b0;
    chk({tag, " mem_req_valid0"}, 64'(o_mrv), 64'd1);
    chk({tag, " mem_req_addr0"}, 64'(o_maddr), 64'(a0));
    step();
    chk({tag, " mem_rsp_ready0"}, 64'(o_mrsr), 64'd1);
    rspv[sel] = 1'b1; rsp_data = d0; mem_rsp_err = 1'b0;
    step();
    rspv[sel] = 1'b0;
    if (split) begin
      chk({tag, " mem_req_valid1"}, 64'(o_mrv), 64'd1);
      chk({tag, " mem_req_addr1"}, 64'(o_maddr), 64'(a1));
      step();
      rspv[sel] = 1'b1; rsp_data = d1;
      step();
      rspv[sel] = 1'b0;
    end
    chk({tag, " wb_valid"}, 64'(o_wbv), 64'd1);
    chk({tag, " wb_data"}, o_wbd, exp);
    chk({tag, " wb_err"}, 64'(o_wbe), 64'd0);
    chk({tag, " wb_rd"}, 64'(o_wbrd), 64'(rd));
    chk({tag, " no_extra_req"}, 64'(o_mrv), 64'd0);
    step();
    chk({tag, " idle"}, 64'(o_rdy), 64'd1);
  endtask

  task automatic bad(input string tag, input logic [31:0] addr, input logic [2:0] f3);
    rv[sel] = 1'b1; req_addr = addr; req_funct3 = f3; req_rd = 5'd3;
    step();
    rv[sel] = 1'b0;
    chk({tag, " mem_req_valid"}, 64'(o_mrv), 64'd0);
    chk({tag, " wb_valid"}, 64'(o_wbv), 64'd1);
    chk({tag, " wb_err"}, 64'(o_wbe), 64'd1);
    chk({tag, " wb_data"}, o_wbd, 64'd0);
    step();
    chk({tag, " idle"}, 64'(o_rdy), 64'd1);
  endtask

  initial begin
    sel = 2'd0; ARESETn = 1'b0;
    for (int i = 0; i < 3; i++) begin rv[i] = 1'b0; rspv[i] = 1'b0; end
    req_addr = '0; req_funct3 = '0; req_rd = '0;
    mem_req_ready = 1'b1; mem_rsp_err = 1'b0; wb_ready = 1'b1; rsp_data = '0;
    step(); step();
    chk("rst req_ready", 64'(o_rdy), 64'd0);
    chk("rst wb_valid", 64'(o_wbv), 64'd0);
    chk("rst mem_req_valid", 64'(o_mrv), 64'd0);
    ARESETn = 1'b1;
    #1;
    chk("rel req_ready", 64'(o_rdy), 64'd1);

    run("lw",   32'h100, F3_LW,  5'd1, 64'hDEADBEEF, 64'h0, 1'b0, 32'h100, 32'h0, 64'hDEADBEEF);
    run("lb",   32'h103, F3_LB,  5'd2, 64'h80112233, 64'h0, 1'b0, 32'h100, 32'h0, 64'hFFFFFF80);
    run("lbu",  32'h103, F3_LBU, 5'd3, 64'h80112233, 64'h0, 1'b0, 32'h100, 32'h0, 64'h00000080);
    run("lh",   32'h102, F3_LH,  5'd4, 64'h80010000, 64'h0, 1'b0, 32'h100, 32'h0, 64'hFFFF8001);
    run("lhu",  32'h101, F3_LHU, 5'd5, 64'h12FEDC34, 64'h0, 1'b0, 32'h100, 32'h0, 64'h0000FEDC);
    run("split", 32'h0FE, F3_LW, 5'd6, 64'hAABBCCDD, 64'h11223344, 1'b1,
        32'h0FC, 32'h100, 64'h3344AABB);
    run("wrap", 32'hFFFFFFFF, F3_LH, 5'd7, 64'h11000000, 64'h000000F2, 1'b1,
        32'hFFFFFFFC, 32'h0, 64'hFFFFF211);
    bad("f3_111", 32'h100, 3'b111);
    bad("ld_on32", 32'h100, F3_LD);
    bad("lwu_on32", 32'h100, F3_LWU);

    // bus error on beat 0 of a split load
    rv[0] = 1'b1; req_addr = 32'h0FE; req_funct3 = F3_LW; req_rd = 5'd8;
    step();
    rv[0] = 1'b0;
    chk("rsperr mem_req_valid", 64'(o_mrv), 64'd1);
    step();
    rspv[0] = 1'b1; rsp_data = 64'h55555555; mem_rsp_err = 1'b1;
    step();
    rspv[0] = 1'b0; mem_rsp_err = 1'b0;
    chk("rsperr wb_valid", 64'(o_wbv), 64'd1);
    chk("rsperr wb_err", 64'(o_wbe), 64'd1);
    chk("rsperr wb_data", o_wbd, 64'd0);
    chk("rsperr no_beat1", 64'(o_mrv), 64'd0);
    step();
    chk("rsperr idle", 64'(o_rdy), 64'd1);

    // backpressure on both the memory request and writeback
    mem_req_ready = 1'b0; wb_ready = 1'b0;
    rv[0] = 1'b1; req_addr = 32'h204; req_funct3 = F3_LW; req_rd = 5'd9;
    step();
    rv[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp mem_req_valid", 64'(o_mrv), 64'd1);
      chk("bp mem_req_addr", 64'(o_maddr), 64'h204);
      chk("bp req_ready", 64'(o_rdy), 64'd0);
      step();
    end
    mem_req_ready = 1'b1;
    chk("bp addr_at_accept", 64'(o_maddr), 64'h204);
    step();
    rspv[0] = 1'b1; rsp_data = 64'h01234567;
    step();
    rspv[0] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("bp wb_valid", 64'(o_wbv), 64'd1);
      chk("bp wb_data", o_wbd, 64'h01234567);
      chk("bp wb_rd", 64'(o_wbrd), 64'd9);
      chk("bp req_ready", 64'(o_rdy), 64'd0);
      step();
    end
    wb_ready = 1'b1;
    chk("bp wb_valid_last", 64'(o_wbv), 64'd1);
    step();
    chk("bp idle", 64'(o_rdy), 64'd1);

    sel = 2'd1;
    #1;
    bad("noalign", 32'h0FE, F3_LW);
    run("n_lh", 32'h102, F3_LH, 5'd10, 64'h7FFF0000, 64'h0, 1'b0, 32'h100, 32'h0, 64'h00007FFF);

    // reset while waiting for beat 1
    sel = 2'd0;
    rv[0] = 1'b1; req_addr = 32'h0FE; req_funct3 = F3_LW; req_rd = 5'd11;
    step();
    rv[0] = 1'b0;
    step();
    rspv[0] = 1'b1; rsp_data = 64'hAABBCCDD;
    step();
    rspv[0] = 1'b0;
    step();
    chk("wt1 mem_rsp_ready", 64'(o_mrsr), 64'd1);
    ARESETn = 1'b0;
    step();
    chk("mid_rst req_ready", 64'(o_rdy), 64'd0);
    chk("mid_rst mem_req_valid", 64'(o_mrv), 64'd0);
    chk("mid_rst mem_rsp_ready", 64'(o_mrsr), 64'd0);
    chk("mid_rst mem_req_addr", 64'(o_maddr), 64'd0);
    chk("mid_rst wb_valid", 64'(o_wbv), 64'd0);
    chk("mid_rst wb_data", o_wbd, 64'd0);
    chk("mid_rst wb_rd", 64'(o_wbrd), 64'd0);
    chk("mid_rst wb_err", 64'(o_wbe), 64'd0);
    ARESETn = 1'b1;
    #1;
    chk("mid_rst release", 64'(o_rdy), 64'd1);

    sel = 2'd2;
    #1;
    run("ld64", 32'h8, F3_LD, 5'd12, 64'h8000000000000001, 64'h0, 1'b0,
        32'h8, 32'h0, 64'h8000000000000001);
    run("lwu64", 32'hC, F3_LWU, 5'd13, 64'hFEDCBA9800000000, 64'h0, 1'b0,
        32'h8, 32'h0, 64'h00000000FEDCBA98);
    run("lw64", 32'hC, F3_LW, 5'd14, 64'hFEDCBA9800000000, 64'h0, 1'b0,
        32'h8, 32'h0, 64'hFFFFFFFFFEDCBA98);
    run("split64", 32'hE, F3_LW, 5'd15, 64'h1122000000000000, 64'h0000000000008899, 1'b1,
        32'h8, 32'h10, 64'hFFFFFFFF88991122);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
